letc_core_irq_sequencer: RTL
============================

// Module: letc_core_irq_sequencer
// PURPOSE
// Interrupt entry sequencer for the 6-stage LETC core pipeline (bit 0 = first fetch stage, bit 5 = writeback).
// Samples the timer and external IRQ lines against the global and per-source enables, then takes the interrupt precisely:
// - halts fetch and squashes the two fetch stages
// - drains the older instructions in stages 2..5
// - hands mcause to the CSR unit and redirects fetch to the trap vector
// Sits beside the hazard unit; its flush and hold outputs are ORed into the pipeline control.
// PARAMETERS
// DRAIN_TIMEOUT  default 64  drain cycles before o_drain_timeout sets; 2..65535
// PORTS
// i_clk                  in   1   core clock
// i_rst_n                in   1   synchronous active-low reset
// i_timer_irq_pending    in   1   machine timer interrupt pending (mip.MTIP)
// i_external_irq_pending in   1   machine external interrupt pending (mip.MEIP)
// i_mstatus_mie          in   1   global machine interrupt enable
// i_mie_mtie             in   1   timer interrupt enable
// i_mie_meie             in   1   external interrupt enable
// i_stage_valid          in   6   per-stage valid instruction
// i_trap_ack             in   1   CSR unit has written mepc/mcause/mstatus
// o_fetch_hold           out  1   block new fetches
// o_stage_flush          out  6   squash per stage
// o_trap_req             out  1   request trap CSR update
// o_trap_cause           out  32  mcause value, valid while o_trap_req
// o_fetch_redirect       out  1   one-cycle pulse: fetch from mtvec
// o_drain_timeout        out  1   sticky: drain exceeded DRAIN_TIMEOUT
// BEHAVIOUR
// Reset: one clock; reset is synchronous and active-low.
// - Reset state IDLE; every output 0; drain counter 0; latched cause 0.
// take = i_mstatus_mie & ((i_external_irq_pending & i_mie_meie) | (i_timer_irq_pending & i_mie_mtie)).
// Priority: external first, cause 32'h8000000B; timer second, cause 32'h80000007.
// IDLE
// - If take: go to DRAIN next cycle and latch the cause (external wins if both are pending).
// - Counter is cleared.
// DRAIN
// - o_fetch_hold=1; o_stage_flush=6'b000011 every cycle; stages 5..2 are never flushed.
// - Counter increments and saturates at 16-bit max.
// - When the counter reaches DRAIN_TIMEOUT, o_drain_timeout sets and holds until reset.
// - Draining continues regardless of the timeout.
// - Abort: if take==0 while in DRAIN, return to IDLE next cycle with no trap.
//   Covers MIE cleared by an older CSR op, or the pending bit dropped.
// - Drained: if take==1 and i_stage_valid[5:2]==0, go to TRAP.
//   Re-latch the cause at this point (a higher priority source may have arrived).
// - Both in the same cycle: abort wins.
// TRAP
// - o_fetch_hold=1, o_stage_flush=6'b000011, o_trap_req=1, o_trap_cause holds the latched value.
// - No abort once in TRAP. Go to REDIRECT on the cycle i_trap_ack=1.
// - o_trap_req may be high for 1 cycle if ack arrives the same cycle.
// REDIRECT
// - o_fetch_redirect=1, o_fetch_hold=1, o_stage_flush=6'b000011 for exactly one cycle, then IDLE.
// - IDLE cannot re-take before one full cycle has passed, so the CSR's cleared MIE is visible.
// - o_trap_cause reads 0 outside TRAP.
// Outputs are registered from state, so latency from a pending IRQ to o_fetch_hold is 1 cycle.
// i_trap_ack outside TRAP is ignored.
// Reset mid-sequence returns to IDLE and drops all outputs that same edge.
// TESTING
// - Timer only, mie/mtie=1, stages 2..5 valid for 3 cycles -> hold at +1; trap_req at +4 with cause 0x80000007;
//   ack -> one redirect pulse -> IDLE.
// - Timer and external asserted together -> cause 0x8000000B.
//   Timer in DRAIN with external arriving before drained -> TRAP cause 0x8000000B.
// - Timer taken, then mstatus_mie dropped in the 2nd DRAIN cycle -> IDLE next cycle; no trap_req, no redirect.
// - DRAIN_TIMEOUT=4, stage 5 valid for 10 cycles -> o_drain_timeout set after 4 DRAIN cycles and stays;
//   trap still taken after drain.
// - Hold i_trap_ack low 5 cycles in TRAP -> trap_req and cause stable; ack while IDLE ignored.
// - Assert i_rst_n=0 in TRAP -> next edge all outputs 0, state IDLE, timeout flag cleared.

Source files
------------

// File: rtl/letc_core_irq_sequencer_if.sv
// Interrupt sequencer bundle: IRQ/enable/pipeline-status inputs and pipeline/CSR control outputs.
interface letc_core_irq_sequencer_if;
  logic        i_timer_irq_pending;
  logic        i_external_irq_pending;
  logic        i_mstatus_mie;
  logic        i_mie_mtie;
  logic        i_mie_meie;
  logic [5:0]  i_stage_valid;
  logic        i_trap_ack;
  logic        o_fetch_hold;
  logic [5:0]  o_stage_flush;
  logic        o_trap_req;
  logic [31:0] o_trap_cause;
  logic        o_fetch_redirect;
  logic        o_drain_timeout;

  // Pipeline / CSR side: drives status, receives control.
  modport master (
    output i_timer_irq_pending, i_external_irq_pending, i_mstatus_mie,
           i_mie_mtie, i_mie_meie, i_stage_valid, i_trap_ack,
    input  o_fetch_hold, o_stage_flush, o_trap_req, o_trap_cause,
           o_fetch_redirect, o_drain_timeout
  );

  // Sequencer side.
  modport slave (
    input  i_timer_irq_pending, i_external_irq_pending, i_mstatus_mie,
           i_mie_mtie, i_mie_meie, i_stage_valid, i_trap_ack,
    output o_fetch_hold, o_stage_flush, o_trap_req, o_trap_cause,
           o_fetch_redirect, o_drain_timeout
  );
endinterface

// File: rtl/letc_core_irq_sequencer.sv
// Interrupt entry sequencer for the 6-stage LETC pipeline: hold fetch, squash
// the fetch stages, drain older work, request the trap CSR update, redirect.
module letc_core_irq_sequencer #(
  parameter int unsigned DRAIN_TIMEOUT = 64
) (
  input logic                         i_clk,
  input logic                         i_rst_n,
  letc_core_irq_sequencer_if.slave    bus
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned CAUSE_W = 32;
  localparam int unsigned STAGES  = 6;

  localparam logic [CAUSE_W-1:0] CAUSE_EXT   = 32'h8000_000B;
  localparam logic [CAUSE_W-1:0] CAUSE_TIMER = 32'h8000_0007;
  localparam logic [STAGES-1:0]  FLUSH_FETCH = 6'b000011;
  localparam logic [STAGES-1:0]  OLDER_MASK  = 6'b111100;
  localparam logic [CNT_W-1:0]   CNT_MAX     = '1;
  localparam logic [CNT_W-1:0]   TIMEOUT_VAL = CNT_W'(DRAIN_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    TRAP,
    REDIRECT
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    drain_cnt;
  logic [CAUSE_W-1:0]  cause_q;
  logic                fetch_hold_q;
  logic [STAGES-1:0]   stage_flush_q;
  logic                trap_req_q;
  logic [CAUSE_W-1:0]  trap_cause_q;
  logic                fetch_redirect_q;
  logic                drain_timeout_q;

  logic                ext_c;
  logic                take_c;
  logic [CAUSE_W-1:0]  cause_c;
  logic                drained_c;
  logic [CNT_W-1:0]    cnt_inc_c;

  // Interrupt qualification, priority select, drain status and saturating count.
  always_comb begin
    ext_c     = bus.i_external_irq_pending & bus.i_mie_meie;
    take_c    = bus.i_mstatus_mie &
                (ext_c | (bus.i_timer_irq_pending & bus.i_mie_mtie));
    cause_c   = ext_c ? CAUSE_EXT : CAUSE_TIMER;
    drained_c = (bus.i_stage_valid & OLDER_MASK) == '0;
    cnt_inc_c = (drain_cnt == CNT_MAX) ? drain_cnt : drain_cnt + CNT_W'(1);
  end

  // Sequencer FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state            <= IDLE;
      drain_cnt        <= '0;
      cause_q          <= '0;
      fetch_hold_q     <= 1'b0;
      stage_flush_q    <= '0;
      trap_req_q       <= 1'b0;
      trap_cause_q     <= '0;
      fetch_redirect_q <= 1'b0;
      drain_timeout_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          drain_cnt <= '0;
          if (take_c) begin
            state         <= DRAIN;
            cause_q       <= cause_c;
            fetch_hold_q  <= 1'b1;
            stage_flush_q <= FLUSH_FETCH;
          end
        end
        DRAIN: begin
          drain_cnt <= cnt_inc_c;
          if (cnt_inc_c >= TIMEOUT_VAL) begin
            drain_timeout_q <= 1'b1;
          end
          // Abort has priority over drained: MIE cleared or pending dropped.
          if (!take_c) begin
            state         <= IDLE;
            fetch_hold_q  <= 1'b0;
            stage_flush_q <= '0;
          end else if (drained_c) begin
            state        <= TRAP;
            cause_q      <= cause_c;
            trap_req_q   <= 1'b1;
            trap_cause_q <= cause_c;
          end
        end
        TRAP: begin
          trap_cause_q <= cause_q;
          if (bus.i_trap_ack) begin
            state            <= REDIRECT;
            trap_req_q       <= 1'b0;
            trap_cause_q     <= '0;
            fetch_redirect_q <= 1'b1;
          end
        end
        REDIRECT: begin
          // Always spend a full IDLE cycle so the CSR's cleared MIE is seen.
          state            <= IDLE;
          fetch_redirect_q <= 1'b0;
          fetch_hold_q     <= 1'b0;
          stage_flush_q    <= '0;
        end
        default: begin
          state            <= IDLE;
          fetch_hold_q     <= 1'b0;
          stage_flush_q    <= '0;
          trap_req_q       <= 1'b0;
          trap_cause_q     <= '0;
          fetch_redirect_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_fetch_hold     = fetch_hold_q;
  assign bus.o_stage_flush    = stage_flush_q;
  assign bus.o_trap_req       = trap_req_q;
  assign bus.o_trap_cause     = trap_cause_q;
  assign bus.o_fetch_redirect = fetch_redirect_q;
  assign bus.o_drain_timeout  = drain_timeout_q;

endmodule
